// File: rtl/pcs_transmit_ordered_set.sv
// pcs_transmit_ordered_set
//   Transmit-side ordered-set scheduler for a 1000BASE-X PCS. Each clock it
//   picks the next code-group for the 8B/10B encoder: idle /I2/ (K28.5,
//   D16.2), start /S/, data, error /V/, end /T/ or carrier-extend /R/. It
//   keeps commas on even code-group positions. Running disparity is the
//   encoder's job.
//
// Ports
//   i_clk            system clock, rising edge
//   i_mr_main_reset  asynchronous active-high reset (released synchronously upstream)
//   i_tx_en          frame transmit enable from the MAC
//   i_tx_er          transmit error from the MAC
//   i_txd[7:0]       transmit octet from the MAC
//   o_tx_code[7:0]   octet to encode (data value or K-code value)
//   o_tx_is_k        1 = o_tx_code is a special (K) code-group
//   o_tx_even        1 = current code-group is on an even position
//   o_tx_busy        1 while /S/, data, /V/, /T/ or /R/ is emitted
module pcs_transmit_ordered_set (
  input  logic       i_clk,
  input  logic       i_mr_main_reset,
  input  logic       i_tx_en,
  input  logic       i_tx_er,
  input  logic [7:0] i_txd,
  output logic [7:0] o_tx_code,
  output logic       o_tx_is_k,
  output logic       o_tx_even,
  output logic       o_tx_busy
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] K_V   = 8'hFE;

  typedef enum logic [2:0] {
    S_I_K  = 3'd0,
    S_I_D  = 3'd1,
    S_DATA = 3'd2,
    S_R1   = 3'd3,
    S_R2   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_code;
  logic       r_is_k;
  logic       r_even;
  logic       r_busy;

  state_t     w_next_state;
  logic [7:0] w_code;
  logic       w_is_k;
  logic       w_busy;
  logic       w_next_even;

  // Parity of the code-group being decided this cycle.
  assign w_next_even = ~r_even;

  always_comb begin
    w_next_state = r_state;
    w_code       = K28_5;
    w_is_k       = 1'b1;
    w_busy       = 1'b0;
    unique case (r_state)
      S_I_K: begin
        if (i_tx_en) begin
          // The octet sampled here is replaced by /S/.
          w_code       = K_S;
          w_busy       = 1'b1;
          w_next_state = S_DATA;
        end else begin
          w_code       = K28_5;
          w_next_state = S_I_D;
        end
      end
      S_I_D: begin
        // Second half of /I2/ is never interrupted, keeping /S/ even.
        w_code       = D16_2;
        w_is_k       = 1'b0;
        w_next_state = S_I_K;
      end
      S_DATA: begin
        w_busy = 1'b1;
        if (i_tx_en) begin
          if (i_tx_er) begin
            w_code = K_V;
          end else begin
            w_code = i_txd;
            w_is_k = 1'b0;
          end
        end else begin
          w_code       = K_T;
          w_next_state = S_R1;
        end
      end
      S_R1: begin
        w_code = K_R;
        w_busy = 1'b1;
        // An /R/ on an even slot needs a second /R/ so idle restarts even.
        w_next_state = w_next_even ? S_R2 : S_I_K;
      end
      S_R2: begin
        w_code       = K_R;
        w_busy       = 1'b1;
        w_next_state = S_I_K;
      end
      default: begin
        w_next_state = S_I_D;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_mr_main_reset) begin
    if (i_mr_main_reset) begin
      r_state <= S_I_D;
      r_code  <= K28_5;
      r_is_k  <= 1'b1;
      r_even  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_code  <= w_code;
      r_is_k  <= w_is_k;
      r_even  <= w_next_even;
      r_busy  <= w_busy;
    end
  end

  assign o_tx_code = r_code;
  assign o_tx_is_k = r_is_k;
  assign o_tx_even = r_even;
  assign o_tx_busy = r_busy;

endmodule

// File: tb/tb_pcs_transmit_ordered_set.sv
// tb_pcs_transmit_ordered_set
//   Directed bench for pcs_transmit_ordered_set. Each step drives the MAC
//   inputs, takes one rising edge and checks the code-group produced by it
//   against a hand-computed value.
module tb_pcs_transmit_ordered_set;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic [7:0] txd = 8'h00;
  logic [7:0] tx_code;
  logic       tx_is_k;
  logic       tx_even;
  logic       tx_busy;

  int n_vec = 0;
  int n_err = 0;

  pcs_transmit_ordered_set dut (
    .i_clk           (clk),
    .i_mr_main_reset (rst),
    .i_tx_en         (tx_en),
    .i_tx_er         (tx_er),
    .i_txd           (txd),
    .o_tx_code       (tx_code),
    .o_tx_is_k       (tx_is_k),
    .o_tx_even       (tx_even),
    .o_tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] c, input logic k,
                       input logic e, input logic b);
    n_vec++;
    assert (tx_code === c) else begin
      n_err++;
      $error("FAIL %s tx_code got %h want %h", tag, tx_code, c);
    end
    n_vec++;
    assert (tx_is_k === k) else begin
      n_err++;
      $error("FAIL %s tx_is_k got %b want %b", tag, tx_is_k, k);
    end
    n_vec++;
    assert (tx_even === e) else begin
      n_err++;
      $error("FAIL %s tx_even got %b want %b", tag, tx_even, e);
    end
    n_vec++;
    assert (tx_busy === b) else begin
      n_err++;
      $error("FAIL %s tx_busy got %b want %b", tag, tx_busy, b);
    end
    $display("%-10s code=%h k=%b even=%b busy=%b", tag, tx_code, tx_is_k, tx_even, tx_busy);
  endtask

  // Drive inputs, take one edge, check the code-group decided at that edge.
  task automatic step(input logic en, input logic er, input logic [7:0] d,
                      input string tag, input logic [7:0] c, input logic k,
                      input logic e, input logic b);
    tx_en = en;
    tx_er = er;
    txd   = d;
    @(posedge clk);
    #1;
    check(tag, c, k, e, b);
  endtask

  initial begin
    // Reset held across edges
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst", 8'hBC, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;

    // Idle after reset: 50 odd first, then alternating; TX_ER alone is idle
    step(0, 0, 8'h00, "idle0", 8'h50, 0, 0, 0);
    step(0, 0, 8'h00, "idle1", 8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "idle2", 8'h50, 0, 0, 0);
    step(0, 1, 8'hA5, "idle3er", 8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "idle4", 8'h50, 0, 0, 0);
    step(0, 0, 8'h00, "idle5", 8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "idle6", 8'h50, 0, 0, 0);
    step(0, 0, 8'h00, "idle7", 8'hBC, 1, 1, 0);

    // Odd-aligned start: AA lost in I_D, 55 replaced by /S/, 2 data octets
    step(1, 0, 8'hAA, "odd_id",  8'h50, 0, 0, 0);
    step(1, 0, 8'h55, "odd_s",   8'hFB, 1, 1, 1);
    step(1, 0, 8'hD5, "odd_d0",  8'hD5, 0, 0, 1);
    step(1, 0, 8'h01, "odd_d1",  8'h01, 0, 1, 1);
    // Even data count: /T/ odd, /R/ even, extra /R/ odd; TX_EN in R1 ignored
    step(0, 0, 8'h00, "odd_t",   8'hFD, 1, 0, 1);
    step(1, 0, 8'h33, "odd_r1",  8'hF7, 1, 1, 1);
    step(0, 0, 8'h00, "odd_r2",  8'hF7, 1, 0, 1);
    step(0, 0, 8'h00, "odd_i0",  8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "odd_i1",  8'h50, 0, 0, 0);

    // Even-aligned frame with 5 data octets: /T/ even, single /R/ odd
    step(1, 0, 8'h55, "ev_s",    8'hFB, 1, 1, 1);
    step(1, 0, 8'h55, "ev_d0",   8'h55, 0, 0, 1);
    step(1, 0, 8'h55, "ev_d1",   8'h55, 0, 1, 1);
    step(1, 0, 8'hD5, "ev_d2",   8'hD5, 0, 0, 1);
    step(1, 0, 8'h01, "ev_d3",   8'h01, 0, 1, 1);
    step(1, 0, 8'h02, "ev_d4",   8'h02, 0, 0, 1);
    step(0, 0, 8'h00, "ev_t",    8'hFD, 1, 1, 1);
    step(0, 0, 8'h00, "ev_r1",   8'hF7, 1, 0, 1);
    step(0, 0, 8'h00, "ev_i0",   8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "ev_i1",   8'h50, 0, 0, 0);

    // Error propagation: /V/ in place of 3C, neighbours untouched
    step(1, 0, 8'h11, "er_s",    8'hFB, 1, 1, 1);
    step(1, 0, 8'h22, "er_d0",   8'h22, 0, 0, 1);
    step(1, 1, 8'h3C, "er_v",    8'hFE, 1, 1, 1);
    step(1, 0, 8'h44, "er_d2",   8'h44, 0, 0, 1);
    step(0, 1, 8'h77, "er_t",    8'hFD, 1, 1, 1);
    step(0, 0, 8'h00, "er_r1",   8'hF7, 1, 0, 1);
    step(0, 0, 8'h00, "er_i0",   8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "er_i1",   8'h50, 0, 0, 0);

    // Minimum frame: /S/ /T/ /R/ /R/ then idle
    step(1, 0, 8'h99, "min_s",   8'hFB, 1, 1, 1);
    step(0, 0, 8'h00, "min_t",   8'hFD, 1, 0, 1);
    step(0, 0, 8'h00, "min_r1",  8'hF7, 1, 1, 1);
    step(0, 0, 8'h00, "min_r2",  8'hF7, 1, 0, 1);
    step(0, 0, 8'h00, "min_i0",  8'hBC, 1, 1, 0);
    step(0, 0, 8'h00, "min_i1",  8'h50, 0, 0, 0);

    // Reset mid-frame: outputs return immediately, then 50 on odd
    step(1, 0, 8'h12, "mr_s",    8'hFB, 1, 1, 1);
    step(1, 0, 8'h34, "mr_d0",   8'h34, 0, 0, 1);
    rst = 1'b1;
    #1;
    check("mr_async", 8'hBC, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("mr_hold", 8'hBC, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    step(0, 0, 8'h00, "mr_i0",   8'h50, 0, 0, 0);
    step(0, 0, 8'h00, "mr_i1",   8'hBC, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
